// File: rtl/output_arbiter.sv
// output_arbiter
//   Two-requester round-robin arbiter feeding a single-entry output buffer.
//   Accepted results are packed into IEEE754 single or double format and
//   presented on out_data one cycle after the accept.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   reqN_valid / reqN_ready      per-requester handshake (0 = add/sub, 1 = mul/div)
//   reqN_mode                    0 = single, 1 = double
//   reqN_sign/_exp/_int          result fields to pack
//   out_valid / out_ready        output handshake
//   out_data                     packed IEEE754 result
//   out_src                      requester that produced out_data
//   out_flags                    {nan, inf}, present only with OUT_ARB_FLAGS_EN
//
// Configuration
//   OUT_ARB_FLAGS_EN  when defined, adds out_flags registered alongside out_data.
//
// State  | meaning
// EMPTY  | buffer empty, out_valid = 0
// FULL   | buffer holds a packed result, out_valid = 1

module output_arbiter #(
  localparam int REG_SIZE                 = 64,
  localparam int OUTPUT_INTERFACE_INT_IN  = 52,
  localparam int OUTPUT_INTERFACE_EXP_IN  = 11
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req0_valid,
  output logic                               req0_ready,
  input  logic                               req0_mode,
  input  logic                               req0_sign,
  input  logic [OUTPUT_INTERFACE_EXP_IN-1:0] req0_exp,
  input  logic [OUTPUT_INTERFACE_INT_IN-1:0] req0_int,
  input  logic                               req1_valid,
  output logic                               req1_ready,
  input  logic                               req1_mode,
  input  logic                               req1_sign,
  input  logic [OUTPUT_INTERFACE_EXP_IN-1:0] req1_exp,
  input  logic [OUTPUT_INTERFACE_INT_IN-1:0] req1_int,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [REG_SIZE-1:0]                out_data,
  output logic                               out_src
`ifdef OUT_ARB_FLAGS_EN
  ,
  output logic [1:0]                         out_flags
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t state;
  logic   last_grant;

  logic grant0, grant1, can_accept, accept, sel;
  logic sel_mode, sel_sign;
  logic [OUTPUT_INTERFACE_EXP_IN-1:0] sel_exp;
  logic [OUTPUT_INTERFACE_INT_IN-1:0] sel_int;
  logic [REG_SIZE-1:0] packed_data;

  // On a tie the requester not served on the last accept wins.
  assign grant0 = req0_valid & (~req1_valid | last_grant);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant);

  // Reset blocks any accept in the cycle it is asserted.
  assign can_accept = ~rst & ((state == EMPTY) | out_ready);

  assign req0_ready = grant0 & can_accept;
  assign req1_ready = grant1 & can_accept;
  assign accept     = req0_ready | req1_ready;
  assign sel        = grant1;

  assign sel_mode = sel ? req1_mode : req0_mode;
  assign sel_sign = sel ? req1_sign : req0_sign;
  assign sel_exp  = sel ? req1_exp  : req0_exp;
  assign sel_int  = sel ? req1_int  : req0_int;

  assign packed_data = sel_mode ? {sel_sign, sel_exp, sel_int}
                                : {32'b0, sel_sign, sel_exp[7:0], sel_int[22:0]};

`ifdef OUT_ARB_FLAGS_EN
  logic exp_ones, frac_zero;
  assign exp_ones  = sel_mode ? (sel_exp == 11'h7FF) : (sel_exp[7:0] == 8'hFF);
  assign frac_zero = sel_mode ? (sel_int == '0) : (sel_int[22:0] == 23'h0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= 1'b0;
      last_grant <= 1'b1;
`ifdef OUT_ARB_FLAGS_EN
      out_flags  <= 2'b00;
`endif
    end else begin
      if (accept) begin
        state      <= FULL;
        out_valid  <= 1'b1;
        out_data   <= packed_data;
        out_src    <= sel;
        last_grant <= sel;
`ifdef OUT_ARB_FLAGS_EN
        out_flags  <= {exp_ones & ~frac_zero, exp_ones & frac_zero};
`endif
      end else if (state == FULL && out_ready) begin
        state     <= EMPTY;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_output_arbiter.sv
module tb_output_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_mode, req0_sign;
  logic [10:0] req0_exp;
  logic [51:0] req0_int;
  logic        req1_valid, req1_ready, req1_mode, req1_sign;
  logic [10:0] req1_exp;
  logic [51:0] req1_int;
  logic        out_valid, out_ready, out_src;
  logic [63:0] out_data;
`ifdef OUT_ARB_FLAGS_EN
  logic [1:0]  out_flags;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  output_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
    .req0_sign(req0_sign), .req0_exp(req0_exp), .req0_int(req0_int),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
    .req1_sign(req1_sign), .req1_exp(req1_exp), .req1_int(req1_int),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src)
`ifdef OUT_ARB_FLAGS_EN
    , .out_flags(out_flags)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] pack(input logic m, input logic s,
                                       input logic [10:0] e, input logic [51:0] f);
    logic [63:0] r;
    if (m) r = ({63'b0, s} << 63) | ({53'b0, e} << 52) | {12'b0, f};
    else   r = ({63'b0, s} << 31) | ({53'b0, e & 11'h0FF} << 23) | ({12'b0, f} & 64'h7F_FFFF);
    return r;
  endfunction

  function automatic logic [1:0] flags(input logic m, input logic [10:0] e, input logic [51:0] f);
    logic ones, zero;
    ones = m ? (e == 11'h7FF) : (e[7:0] == 8'hFF);
    zero = m ? (f == 52'h0) : (f[22:0] == 23'h0);
    return {ones && !zero, ones && zero};
  endfunction

  // Which requester the rules pick (-1 when nobody is asking).
  function automatic int who(input logic v0, input logic v1, input logic last);
    if (!v0 && !v1) return -1;
    if (v0 && v1)   return last ? 0 : 1;
    return v0 ? 0 : 1;
  endfunction

  logic        m_on = 1'b0;
  logic        m_valid, m_src, m_last;
  logic [63:0] m_data;
  logic [1:0]  m_flags;

  always @(posedge clk) begin
    int w;
    if (rst) begin
      m_valid = 0; m_data = 0; m_src = 0; m_last = 1; m_flags = 0; m_on = 1;
    end else if (m_on) begin
      w = who(req0_valid, req1_valid, m_last);
      if (w >= 0 && (!m_valid || out_ready)) begin
        m_valid = 1;
        m_src   = (w == 1);
        m_last  = (w == 1);
        m_data  = (w == 1) ? pack(req1_mode, req1_sign, req1_exp, req1_int)
                           : pack(req0_mode, req0_sign, req0_exp, req0_int);
        m_flags = (w == 1) ? flags(req1_mode, req1_exp, req1_int)
                           : flags(req0_mode, req0_exp, req0_int);
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    int w;
    logic open;
    if (m_on) begin
      w    = who(req0_valid, req1_valid, m_last);
      open = !rst && (!m_valid || out_ready);
      chk("m_req0_ready", {63'b0, req0_ready}, {63'b0, open && w == 0});
      chk("m_req1_ready", {63'b0, req1_ready}, {63'b0, open && w == 1});
      chk("m_out_valid",  {63'b0, out_valid},  {63'b0, m_valid});
      chk("m_out_data",   out_data,            m_data);
      chk("m_out_src",    {63'b0, out_src},    {63'b0, m_src});
`ifdef OUT_ARB_FLAGS_EN
      chk("m_out_flags",  {62'b0, out_flags},  {62'b0, m_flags});
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic set0(input logic v, input logic m, input logic s,
                      input logic [10:0] e, input logic [51:0] f);
    req0_valid = v; req0_mode = m; req0_sign = s; req0_exp = e; req0_int = f;
  endtask

  task automatic set1(input logic v, input logic m, input logic s,
                      input logic [10:0] e, input logic [51:0] f);
    req1_valid = v; req1_mode = m; req1_sign = s; req1_exp = e; req1_int = f;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; out_ready = 0;
    set0(1, 0, 0, 11'h0, 52'h0);
    set1(0, 0, 0, 11'h0, 52'h0);
    step();
    chk("rst_blocks_ready0", {63'b0, req0_ready}, 64'h0);
    step();
    rst = 0; req0_valid = 0;
    #1;
    chk("reset_out_valid", {63'b0, out_valid}, 64'h0);
    chk("reset_out_data",  out_data,           64'h0);
    chk("reset_out_src",   {63'b0, out_src},   64'h0);

    // double pack
    set0(1, 1, 1, 11'h400, 52'h8_0000_0000_0000); out_ready = 1;
    #1 chk("dbl_ready0", {63'b0, req0_ready}, 64'h1);
    step(); req0_valid = 0;
    chk("dbl_valid", {63'b0, out_valid}, 64'h1);
    chk("dbl_data",  out_data, 64'hC008_0000_0000_0000);
    chk("dbl_src",   {63'b0, out_src}, 64'h0);

    // single pack
    set1(1, 0, 0, 11'h07F, 52'h0);
    #1 chk("sgl_ready1", {63'b0, req1_ready}, 64'h1);
    step(); req1_valid = 0;
    chk("sgl_data", out_data, 64'h0000_0000_3F80_0000);
    chk("sgl_src",  {63'b0, out_src}, 64'h1);

    // round-robin, no bubbles
    set0(1, 0, 1, 11'h080, 52'h0);
    set1(1, 1, 0, 11'h3FF, 52'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ready0", {63'b0, req0_ready}, {63'b0, i % 2 == 0});
      chk("rr_ready1", {63'b0, req1_ready}, {63'b0, i % 2 == 1});
      step();
      chk("rr_src",   {63'b0, out_src},   {63'b0, i % 2 == 1});
      chk("rr_valid", {63'b0, out_valid}, 64'h1);
      chk("rr_data",  out_data, (i % 2 == 1) ? 64'h3FF0_0000_0000_0000 : 64'h0000_0000_C000_0000);
    end

    // back-pressure holds buffer, then same-cycle accept
    req1_valid = 0; out_ready = 0;
    set0(1, 1, 0, 11'h401, 52'h4_0000_0000_0000);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready0", {63'b0, req0_ready}, 64'h0);
      step();
      chk("bp_data", out_data, 64'h3FF0_0000_0000_0000);
      chk("bp_src",  {63'b0, out_src}, 64'h1);
    end
    out_ready = 1;
    #1 chk("bp_release_ready0", {63'b0, req0_ready}, 64'h1);
    step(); req0_valid = 0;
    chk("bp_new_data", out_data, 64'h4014_0000_0000_0000);
    chk("bp_new_src",  {63'b0, out_src}, 64'h0);

    // reset while FULL discards the held result
    out_ready = 0; rst = 1; req1_valid = 1;
    #1;
    chk("midrst_ready0", {63'b0, req0_ready}, 64'h0);
    chk("midrst_ready1", {63'b0, req1_ready}, 64'h0);
    step(); rst = 0; req1_valid = 0;
    chk("midrst_valid", {63'b0, out_valid}, 64'h0);
    chk("midrst_data",  out_data, 64'h0);
    out_ready = 1;
    step();
    chk("midrst_no_emit", {63'b0, out_valid}, 64'h0);

    // invalid inputs leave out_data alone
    set0(0, 1, 1, 11'h7FF, 52'h123);
    step();
    chk("invalid_data", out_data, 64'h0);

    // req0 first after reset; stalled grants do not rotate priority
    set0(1, 0, 0, 11'h0, 52'h1);
    #1 chk("prio_ready0", {63'b0, req0_ready}, 64'h1);
    step();
    chk("prio_data", out_data, 64'h1);
    out_ready = 0;
    set1(1, 1, 1, 11'h0, 52'h0);
    step(); step();
    out_ready = 1;
    #1;
    chk("norot_ready1", {63'b0, req1_ready}, 64'h1);
    chk("norot_ready0", {63'b0, req0_ready}, 64'h0);
    step(); req0_valid = 0; req1_valid = 0;
    chk("norot_src",  {63'b0, out_src}, 64'h1);
    chk("norot_data", out_data, 64'h8000_0000_0000_0000);
    step();
    chk("empty_valid",     {63'b0, out_valid}, 64'h0);
    chk("empty_hold_data", out_data, 64'h8000_0000_0000_0000);

`ifdef OUT_ARB_FLAGS_EN
    set0(1, 1, 0, 11'h7FF, 52'h1);
    step();
    chk("nan_data",  out_data, 64'h7FF0_0000_0000_0001);
    chk("nan_flags", {62'b0, out_flags}, 64'h2);
    set0(1, 0, 0, 11'h0FF, 52'h0);
    step(); req0_valid = 0;
    chk("inf_data",  out_data, 64'h0000_0000_7F80_0000);
    chk("inf_flags", {62'b0, out_flags}, 64'h1);
`endif

    // mixed traffic checked by the model alone
    for (int i = 0; i < 80; i++) begin
      set0($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
           11'($urandom), {20'($urandom), 32'($urandom)});
      set1($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
           (i % 7 == 0) ? 11'h7FF : 11'($urandom), (i % 5 == 0) ? 52'h0 : {20'($urandom), 32'($urandom)});
      out_ready = ($urandom_range(0, 3) != 0);
      rst = (i == 50);
      step();
    end
    rst = 0; req0_valid = 0; req1_valid = 0; out_ready = 1;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
